// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Handshaked pipeline stage register carrying a packed payload between two
// pipeline stages (ID/EX, EX/MEM, MEM/WB, ...).
//
// SKID = 1 : main entry plus a 2nd "skid" entry. in_ready comes straight from
//            a flop (!skid_v), so no combinational path runs from out_ready to
//            in_ready.
// SKID = 0 : single main entry. in_ready = !main_v | out_ready
//            (combinational through out_ready).
//
// Handshake: a beat moves across an interface on a rising edge where both
// valid and ready are high (accept = in_valid & in_ready, deliver =
// out_valid & out_ready). A producer may offer a beat any cycle; nothing is
// implied by valid or ready alone. Beats leave in acceptance order.
//
// flush kills every held beat on the next edge. A beat offered in the flush
// cycle is dropped. The beat on out_* still counts as delivered if out_ready
// was high. Payload registers keep their contents across a flush.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous kill of all held beats
//   in_valid   in   upstream beat present
//   in_ready   out  stage accepts a beat this cycle
//   in_data    in   upstream payload [DATA_WIDTH]
//   out_valid  out  downstream beat present (flop)
//   out_ready  in   downstream accepts this cycle
//   out_data   out  downstream payload [DATA_WIDTH] (flop)
//   count      out  beats held: 0..1 (SKID=0), 0..2 (SKID=1)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    SKID        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            count
);

  logic accept;
  logic deliver;

  // A beat offered during flush is never taken, even if in_ready is high.
  assign accept  = in_valid & in_ready & ~flush;
  assign deliver = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    logic                  main_v;
    logic                  skid_v;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] skid_d;

    // Invariant: skid_v implies main_v, so skid only ever holds the
    // younger of two beats.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        main_d <= RESET_VALUE;
        skid_d <= RESET_VALUE;
      end else if (flush) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
      end else if (deliver && skid_v) begin
        // in_ready is low here, so no accept can coincide with this refill.
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (accept && (!main_v || deliver)) begin
        // Main empty, or main leaving with skid empty: replace main.
        main_v <= 1'b1;
        main_d <= in_data;
      end else if (accept) begin
        // Main is held by backpressure: park the beat in skid.
        skid_v <= 1'b1;
        skid_d <= in_data;
      end else if (deliver) begin
        main_v <= 1'b0;
      end
    end

    assign in_ready  = ~skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign count     = {1'b0, main_v} + {1'b0, skid_v};
  end else begin : g_single
    logic                  main_v;
    logic [DATA_WIDTH-1:0] main_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_v <= 1'b0;
        main_d <= RESET_VALUE;
      end else if (flush) begin
        main_v <= 1'b0;
      end else if (accept) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end else if (deliver) begin
        main_v <= 1'b0;
      end
    end

    assign in_ready  = ~main_v | out_ready;
    assign out_valid = main_v;
    assign out_data  = main_d;
    assign count     = {1'b0, main_v};
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline stage register for the CPU core. It replaces fixed per-field stall/flop inter-stage registers such as EX→MEM with one valid/ready stage. The stage carries a packed payload of configurable width. It provides:
- an optional 2-entry skid buffer, so the upstream ready is a registered signal;
- a synchronous flush that kills in-flight beats.

It sits between any two pipeline stages, for example ID/EX, EX/MEM or MEM/WB.

## Interface
- DATA_WIDTH, 32: payload width in bits; must be ≥1.
- RESET_VALUE, 0: value loaded into the payload registers on reset. Width is DATA_WIDTH.
- SKID, 1: selects the mode.
  - 1: 2-entry skid buffer; `in_ready` is registered.
  - 0: single register; `in_ready` is combinational.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held beats.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_WIDTH  downstream payload.
- count  out  2  number of beats held: 0..1 when SKID=0, 0..2 when SKID=1.

## Operation
- Accept: `in_valid & in_ready`. Deliver: `out_valid & out_ready`.
- State is a main entry (main_v, main_d) and, when SKID=1, a skid entry (skid_v, skid_d).
- `out_valid` = main_v and `out_data` = main_d; both are driven directly from flops.
- SKID=1:
  - `in_ready` = !skid_v, taken from the flop only and never dependent on `out_ready`.
  - Accept with main empty, or with main being delivered and skid empty: the beat goes to main.
  - Accept while main is held (main_v & !out_ready): the beat goes to skid.
  - Deliver with skid_v: skid moves to main and skid_v clears. An accept in the same cycle is impossible because `in_ready`=0.
- SKID=0:
  - `in_ready` = !main_v | out_ready.
  - Accept loads main. Deliver without accept clears main_v.
- Flush, highest priority after reset:
  - On the next edge main_v and skid_v clear.
  - A beat offered in the flush cycle is dropped, even though `in_ready` may be 1.
  - Payload registers keep their values.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.
- `count` = main_v + skid_v.
- Reset values: main_v=0, skid_v=0, main_d=skid_d=RESET_VALUE. After reset, `out_valid`=0, `out_data`=RESET_VALUE, `count`=0, `in_ready`=1 in both modes.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat/cycle when `out_ready` stays high, in both modes.
- SKID=1 backpressure: `out_ready` falling at cycle N still lets the beat offered in cycle N be accepted into skid. `in_ready` falls after that edge.
- SKID=1 recovery: `in_ready` rises one cycle after the first deliver that empties skid.
- Simultaneous accept + deliver with skid empty: main is replaced and `count` is unchanged.
- Reset asserted mid-transfer: all valids clear immediately, without waiting for a clock edge. Beats in flight are lost. The first accept is possible on the first edge after `rst` deasserts.
- Flush together with `out_ready`=1 in the same cycle: the beat on `out_*` counts as delivered because its handshake completed. Everything else clears.

## Test plan
- Reset: assert `rst` asynchronously between edges → `out_valid`=0, `out_data`=RESET_VALUE, `count`=0 and `in_ready`=1 before the next edge.
- Streaming, SKID=1, `out_ready`=1: send 0x11, 0x22, 0x33 on consecutive cycles → they appear on consecutive cycles, each one cycle after its accept, with `count`=1 throughout.
- Backpressure, SKID=1:
  - Stimulus: hold `out_ready`=0 while offering 0xA0, 0xA1, 0xA2.
  - While `out_ready`=0: 0xA0 and 0xA1 are accepted, `count`=2, `in_ready`=0, and 0xA2 is held off.
  - After raising `out_ready`: the output order is 0xA0, 0xA1, 0xA2 with no gap.
- Flush with stage full: `count`=2 with payloads 0x5, 0x6; pulse `flush` while offering 0x7 → next cycle `count`=0 and `out_valid`=0; 0x7 never appears.
- SKID=0 mode: `out_ready`=0 with main full → `in_ready`=0 combinationally. Raise `out_ready` with 0x9 offered → same-cycle accept, and 0x9 is on `out_data` next cycle.
- Randomised valid/ready, 10k beats, both modes: the output sequence equals the input sequence, and `count` matches a reference model every cycle.
